// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box constants, FSM state type and lookup helper for the
// sequential SubBytes engine.
package aes_sbox_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } subseq_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: forward or inverse substitution of a single byte.
module aes_sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  always_comb begin
    out_byte = sbox_lookup(in_byte, inv);
  end

endmodule

// File: rtl/aes_subbytes_seq.sv
// Sequential AES SubBytes/InvSubBytes engine: LANES S-boxes sweep the latched
// state in place over NBYTES/LANES cycles, with valid/ready on both sides.
module aes_subbytes_seq
  import aes_sbox_pkg::*;
#(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [8*NBYTES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);

  localparam int NCYC = (LANES > 0) ? NBYTES / LANES : 1;
  localparam int CNTW = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NCYC - 1);

  if (LANES == 0) begin : g_bad_lanes
    $error("aes_subbytes_seq: LANES must be non-zero");
  end else if ((NBYTES % LANES) != 0) begin : g_bad_ratio
    $error("aes_subbytes_seq: NBYTES must be a multiple of LANES");
  end

  subseq_state_t   fsm_q, fsm_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [7:0]      data_q [NBYTES];
  logic [7:0]      data_d [NBYTES];
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];
  logic            accept;

  // Lane l of sweep step cnt works on byte cnt*LANES + l.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = data_q[IDXW'(32'(cnt_q) * LANES + l)];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lane u_lane (
      .in_byte  (lane_in[g]),
      .inv      (mode_q),
      .out_byte (lane_out[g])
    );
  end

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    data_d   = data_q;
    in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    unique case (fsm_q)
      IDLE: begin
        if (accept) fsm_d = SUB;
      end
      SUB: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          data_d[IDXW'(32'(cnt_q) * LANES + l)] = lane_out[l];
        end
        if (cnt_q == CNT_LAST) fsm_d = DONE;
        else                   cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        if (out_ready) fsm_d = in_valid ? SUB : IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    // A new block overrides the DONE hand-off in the same cycle (back-to-back).
    if (accept) begin
      cnt_d  = '0;
      mode_d = in_mode;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        data_d[i] = in_data[8*(NBYTES-1-i) +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q  <= IDLE;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == SUB);
    out_data  = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      out_data[8*(NBYTES-1-i) +: 8] = data_q[i];
    end
  end

endmodule
